shared_mul_gf2n: RTL
====================

// Module: shared_mul_gf2n
// PURPOSE
//  Masked (DOM-indep) multiplier over GF(2^N) for any share count, with a valid-tagged pipeline.
//  Generalises the fixed-width GF(2^2) shared multiplier used in the masked AES S-box datapath.
//  Takes N, the share count, reduction polynomial and pipelining as parameters.
//  Inner-domain and cross-domain terms are registered before compression; cross terms carry fresh randomness.
// PARAMETERS
//  N         2       field degree, 2..8
//  SHARES    3       number of Boolean shares, >=2 (protection order SHARES-1)
//  POLY      3'b111  reduction polynomial, N+1 bits, MSB=x^N; default x^2+x+1
//  PIPELINED 1       1: inner-domain products also registered, 2-stage; 0: 1-stage
// PORTS
//  ClkxCI    in   1                       clock, rising edge
//  RstxRI    in   1                       synchronous, active-high reset
//  ValidxSI  in   1                       input shares and randomness valid this cycle
//  _XxDI     in   N*SHARES                share i of X at bits [i*N +: N]
//  _YxDI     in   N*SHARES                share i of Y at bits [i*N +: N]
//  _ZxDI     in   N*SHARES*(SHARES-1)/2   fresh random, pair k at bits [k*N +: N]
//  ValidxSO  out  1                       _QxDO holds a valid result
//  _QxDO     out  N*SHARES                share i of Q=X*Y at bits [i*N +: N]
// BEHAVIOUR
//  Reset: when RstxRI=1 at a clock edge, all stage registers, ValidxSO and _QxDO go to 0.
//  Field product mul(a,b): carry-less product of a and b, reduced mod POLY, N-bit result.
//  Pair index k: enumerate (i,j) with i<j, i outer, ascending.
//   Example, SHARES=3: (0,1)=0, (0,2)=1, (1,2)=2.
//  Stage 1, loads only when ValidxSI=1; otherwise it holds its value:
//   C[i][j] <= mul(X_i,Y_j) ^ Z_k, for every i!=j, with k=pair(min(i,j),max(i,j)).
//   PIPELINED=1: I[i] <= mul(X_i,Y_i).
//   V1 <= ValidxSI on every edge.
//  Stage 2, PIPELINED=1: loads only when V1=1:
//   Q_i <= I[i] ^ XOR over j!=i of C[i][j].
//   ValidxSO <= V1.
//   Latency is 2 cycles. One result per cycle; no backpressure.
//  PIPELINED=0: the inner products are combinational from the live inputs.
//   Q_i = mul(X_i,Y_i) ^ XOR C[i][j], with the register on C only.
//   Output is driven from stage 1; ValidxSO=V1; latency 1.
//   The caller must hold X/Y for 1 cycle after ValidxSI.
//  Correctness: XOR over i of Q_i equals mul(XOR X_i, XOR Y_i) for any Z value.
//  Cross terms must never combine different domains before the register; this is a glitch-safety rule.
//  ValidxSI=0 bubbles: registers hold, and ValidxSO drops exactly LAT cycles later.
//   _QxDO keeps its last valid value.
//  Back-to-back valid inputs: every one produces a result, in order, with no gaps.
//  Reset mid-operation: in-flight results are discarded.
//   ValidxSO=0 on the cycle after the reset edge.
//   The first valid after reset appears LAT cycles after its input.
//  ValidxSI=1 with RstxRI=1 on the same edge: reset wins and the input is dropped.
//  Elaboration error if SHARES<2, N<2, or POLY[N]!=1.
// TESTING
//  T1: N=2, SHARES=3, default POLY, Z=0, share1=share2=0. Apply all 16 X,Y pairs.
//   -> XOR of Q shares equals the GF(4) product. Checks: 2*2=3, 2*3=1, 3*3=2, 0*y=0.
//   -> ValidxSO rises 2 cycles after ValidxSI.
//  T2: same 16 pairs, random nonzero shares and random Z each cycle.
//   -> Unmasked result is identical to T1. Individual Q shares differ from T1.
//  T3: N=4, SHARES=2, POLY=5'b10011. X=4'h2, Y=4'h9.
//   -> Unmasked Q=4'h1. Also check 4'h8*4'h8=4'hC.
//  T4: valid pattern 1,1,0,1 with 4 distinct X/Y.
//   -> Exactly 3 results in order at cycles 2, 3 and 5. Q holds during the gap.
//  T5: assert RstxRI for 1 cycle while 2 results are in flight.
//   -> ValidxSO=0 and _QxDO=0 after the edge; no stale result is emitted.
//  T6: PIPELINED=0, SHARES=4, random stimulus.
//   -> Latency 1 and the unmasked product is correct.

Source files
------------

// File: rtl/shared_mul_gf2n.sv
// shared_mul_gf2n
//   Masked (DOM-indep) multiplier over GF(2^N) with any number of Boolean
//   shares and a valid-tagged pipeline. Cross-domain products are blinded
//   with fresh randomness and registered before compression. Inner-domain
//   products are either registered as well (PIPELINED=1, latency 2) or
//   combinational from the live inputs (PIPELINED=0, latency 1). When
//   PIPELINED=0 the caller holds X/Y for one cycle after ValidxSI.
//
// Ports
//   ClkxCI    clock, rising edge
//   RstxRI    synchronous active-high reset
//   ValidxSI  input shares and randomness valid this cycle
//   _XxDI     share i of X at [i*N +: N]
//   _YxDI     share i of Y at [i*N +: N]
//   _ZxDI     fresh randomness, pair k at [k*N +: N]
//   ValidxSO  _QxDO holds a valid result
//   _QxDO     share i of Q = X*Y at [i*N +: N]
module shared_mul_gf2n #(
  parameter int unsigned N         = 2,
  parameter int unsigned SHARES    = 3,
  parameter logic [N:0]  POLY      = 3'b111,
  parameter int unsigned PIPELINED = 1
) (
  input  logic                              ClkxCI,
  input  logic                              RstxRI,
  input  logic                              ValidxSI,
  input  logic [N*SHARES-1:0]               _XxDI,
  input  logic [N*SHARES-1:0]               _YxDI,
  input  logic [N*SHARES*(SHARES-1)/2-1:0]  _ZxDI,
  output logic                              ValidxSO,
  output logic [N*SHARES-1:0]               _QxDO
);

  localparam int unsigned NPAIR  = SHARES * (SHARES - 1) / 2;
  localparam int unsigned NCROSS = SHARES - 1;

  if (SHARES < 2 || N < 2 || POLY[N] != 1'b1) begin : g_bad_params
    $error("shared_mul_gf2n: invalid N, SHARES or POLY");
  end

  // Shift-and-add multiply with reduction folded into every shift step.
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      acc = {acc[N-1:0], 1'b0};
      if (acc[N]) acc = acc ^ POLY;
      if (b[N-1-i]) acc = acc ^ {1'b0, a};
    end
    return acc[N-1:0];
  endfunction

  // Cross terms of share i are stored densely: slot jj covers partner j,
  // skipping j==i, so no register is wasted on the diagonal.
  function automatic int unsigned partner(input int unsigned i, input int unsigned jj);
    return (jj < i) ? jj : jj + 1;
  endfunction

  // Pair (lo,hi) with lo<hi enumerated lo-outer ascending.
  function automatic int unsigned pair_idx(input int unsigned a, input int unsigned b);
    int unsigned lo;
    int unsigned hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic [SHARES-1:0][N-1:0]             x_sh;
  logic [SHARES-1:0][N-1:0]             y_sh;
  logic [NPAIR-1:0][N-1:0]              z_pr;
  logic [SHARES-1:0][N-1:0]             inner;
  logic [SHARES-1:0][N-1:0]             q_sum;
  logic [SHARES-1:0][NCROSS-1:0][N-1:0] c_d, c_q;
  logic                                 v1_d, v1_q;

  always_comb begin
    x_sh = _XxDI;
    y_sh = _YxDI;
    z_pr = _ZxDI;
  end

  // Each cross term mixes exactly one X domain and one Y domain with its
  // own mask and is registered before any compression.
  always_comb begin
    v1_d = ValidxSI;
    c_d  = c_q;
    if (ValidxSI) begin
      for (int unsigned i = 0; i < SHARES; i++) begin
        for (int unsigned jj = 0; jj < NCROSS; jj++) begin
          c_d[i][jj] = gf_mul(x_sh[i], y_sh[partner(i, jj)]) ^ z_pr[pair_idx(i, partner(i, jj))];
        end
      end
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      v1_q <= 1'b0;
      c_q  <= '0;
    end else begin
      v1_q <= v1_d;
      c_q  <= c_d;
    end
  end

  always_comb begin
    q_sum = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      q_sum[i] = inner[i];
      for (int unsigned jj = 0; jj < NCROSS; jj++) begin
        q_sum[i] = q_sum[i] ^ c_q[i][jj];
      end
    end
  end

  if (PIPELINED != 0) begin : g_pipe
    logic [SHARES-1:0][N-1:0] i_d, i_q;
    logic [SHARES-1:0][N-1:0] q_d, q_q;
    logic                     vo_d, vo_q;

    always_comb begin
      i_d = i_q;
      if (ValidxSI) begin
        for (int unsigned i = 0; i < SHARES; i++) begin
          i_d[i] = gf_mul(x_sh[i], y_sh[i]);
        end
      end
    end

    always_comb begin
      inner = i_q;
      q_d   = v1_q ? q_sum : q_q;
      vo_d  = v1_q;
    end

    always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
        i_q  <= '0;
        q_q  <= '0;
        vo_q <= 1'b0;
      end else begin
        i_q  <= i_d;
        q_q  <= q_d;
        vo_q <= vo_d;
      end
    end

    always_comb begin
      ValidxSO = vo_q;
      _QxDO    = q_q;
    end
  end else begin : g_comb
    always_comb begin
      inner = '0;
      for (int unsigned i = 0; i < SHARES; i++) begin
        inner[i] = gf_mul(x_sh[i], y_sh[i]);
      end
    end

    always_comb begin
      ValidxSO = v1_q;
      _QxDO    = q_sum;
    end
  end

endmodule
